// File: rtl/fetch_queue.sv
// fetch_queue: show-ahead instruction prefetch buffer between IF and decode.
// Holds fetched words with their fetch addresses so fetch can run ahead of a
// stalled decode. A taken-branch flush discards every queued wrong-path entry.
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int INST_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     v_i,
    input  logic [INST_W-1:0]        inst_i,
    input  logic [ADDR_W-1:0]        origaddr_i,
    input  logic                     flush_i,
    input  logic                     stall_i,
    output logic                     v_o,
    output logic [INST_W-1:0]        inst_o,
    output logic [ADDR_W-1:0]        origaddr_o,
    output logic                     stall_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     ovf_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Occupancy thresholds: completely full, and the early-stall point that
    // leaves one slot for the word already in flight from instruction memory.
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] HIGH_CNT = CNT_W'(DEPTH - 1);

    // Entry storage; data is never reset, only the pointers and count are.
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [ADDR_W-1:0] addr_mem [DEPTH];

    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              ovf_q;

    logic              full;
    logic              pop;
    logic              push;
    logic              ovf_set;

    // Handshake decode: flush wins over everything, and a full queue accepts
    // a new word only when the head leaves in the same cycle.
    always_comb begin
        full    = (count == FULL_CNT);
        pop     = (count != '0) & ~stall_i & ~flush_i;
        push    = v_i & ~flush_i & (~full | pop);
        ovf_set = v_i & ~flush_i & full & ~pop;
    end

    // Pointer, occupancy and sticky overflow state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Entry write; instruction and address are stored together so they stay paired.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= inst_i;
            addr_mem[wr_ptr] <= origaddr_i;
        end
    end

    // Show-ahead head and status, all decoded from registered state.
    always_comb begin
        v_o        = (count != '0);
        inst_o     = inst_mem[rd_ptr];
        origaddr_o = addr_mem[rd_ptr];
        stall_o    = (count >= HIGH_CNT);
        count_o    = count;
        ovf_o      = ovf_q;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue (DEPTH=4, 16-bit words).
module tb_fetch_queue;

    typedef struct packed {
        logic [15:0] inst;
        logic [15:0] addr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        v_i;
    logic [15:0] inst_i;
    logic [15:0] origaddr_i;
    logic        flush_i;
    logic        stall_i;
    logic        v_o;
    logic [15:0] inst_o;
    logic [15:0] origaddr_o;
    logic        stall_o;
    logic [2:0]  count_o;
    logic        ovf_o;

    ent_t sb[$];
    int   mcount;
    logic movf;
    int   errors = 0;
    int   checks = 0;

    logic popped;
    logic got_v;
    ent_t got_pop;
    ent_t exp_pop;

    fetch_queue #(.DEPTH(4), .INST_W(16), .ADDR_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .v_i        (v_i),
        .inst_i     (inst_i),
        .origaddr_i (origaddr_i),
        .flush_i    (flush_i),
        .stall_i    (stall_i),
        .v_o        (v_o),
        .inst_o     (inst_o),
        .origaddr_o (origaddr_o),
        .stall_o    (stall_o),
        .count_o    (count_o),
        .ovf_o      (ovf_o)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs at a negedge, capture the head if it is consumed,
    // advance the reference queue, and return at the following negedge.
    task automatic apply(input logic v, input logic [15:0] inst, input logic [15:0] addr,
                         input logic stall, input logic flush);
        logic pop_m;
        logic push_m;
        v_i        = v;
        inst_i     = inst;
        origaddr_i = addr;
        stall_i    = stall;
        flush_i    = flush;
        popped     = 1'b0;
        pop_m      = (mcount != 0) && !stall && !flush;
        if (flush) begin
            sb.delete();
            mcount = 0;
        end else begin
            if (pop_m) begin
                popped  = 1'b1;
                got_v   = v_o;
                got_pop = {inst_o, origaddr_o};
                exp_pop = sb.pop_front();
            end
            push_m = v && (mcount < 4 || pop_m);
            if (v && mcount == 4 && !pop_m) movf = 1'b1;
            if (push_m) sb.push_back({inst, addr});
            mcount = mcount + int'(push_m) - int'(pop_m);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst        = 1'b0;
        v_i        = 1'b1;
        inst_i     = 16'h7777;
        origaddr_i = 16'h7770;
        stall_i    = 1'b0;
        flush_i    = 1'b0;
        repeat (n) @(negedge clk);
        rst  = 1'b1;
        v_i  = 1'b0;
        sb.delete();
        mcount = 0;
        movf   = 1'b0;
    endtask

    task automatic test_reset;
        do_reset(2);
        checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL reset_v_o got=%b exp=0", v_o); end
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count_o); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
        checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf_o); end
        apply(1'b1, 16'h1111, 16'h0000, 1'b1, 1'b0);
        checks++; if (v_o !== 1'b1) begin errors++; $display("FAIL first_v_o got=%b exp=1", v_o); end
        checks++; if (inst_o !== 16'h1111) begin errors++; $display("FAIL first_inst got=%h exp=1111", inst_o); end
        checks++; if (origaddr_o !== 16'h0000) begin errors++; $display("FAIL first_addr got=%h exp=0000", origaddr_o); end
        apply(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        checks++; if (!popped || got_pop !== exp_pop) begin errors++; $display("FAIL first_pop got=%h exp=%h popped=%b", got_pop, exp_pop, popped); end
        checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL first_empty got=%b exp=0", v_o); end
    endtask

    task automatic test_fill_drain;
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 16'hA000 + 16'(i), 16'h0100 + 16'(2 * i), 1'b1, 1'b0);
            checks++; if (count_o !== 3'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count_o, i + 1); end
            checks++; if (stall_o !== (i + 1 >= 3)) begin errors++; $display("FAIL fill_stall[%0d] got=%b exp=%b", i, stall_o, (i + 1 >= 3)); end
            checks++; if (v_o !== 1'b1 || inst_o !== 16'hA000) begin errors++; $display("FAIL fill_head[%0d] got=%b/%h exp=1/a000", i, v_o, inst_o); end
        end
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            checks++; if (!popped || got_v !== 1'b1 || got_pop !== exp_pop) begin errors++; $display("FAIL drain[%0d] got=%h exp=%h v=%b", i, got_pop, exp_pop, got_v); end
            checks++; if (count_o !== 3'(mcount)) begin errors++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, count_o, mcount); end
        end
        checks++; if (v_o !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b/%b exp=0/0", v_o, stall_o); end
    endtask

    task automatic test_stream;
        for (int i = 0; i < 10; i++) begin
            apply(1'b1, 16'hC000 + 16'(i), 16'h0200 + 16'(i), 1'b0, 1'b0);
            if (i > 0) begin
                checks++; if (!popped || got_pop !== exp_pop) begin errors++; $display("FAIL stream[%0d] got=%h exp=%h", i, got_pop, exp_pop); end
            end
            checks++; if (count_o !== 3'd1 || v_o !== 1'b1) begin errors++; $display("FAIL stream_occ[%0d] got=%0d/%b exp=1/1", i, count_o, v_o); end
        end
        apply(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        checks++; if (!popped || got_pop !== exp_pop) begin errors++; $display("FAIL stream_last got=%h exp=%h", got_pop, exp_pop); end
    endtask

    task automatic test_flush;
        for (int i = 0; i < 3; i++) apply(1'b1, 16'hF000 + 16'(i), 16'h0400 + 16'(i), 1'b1, 1'b0);
        checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL preflush_count got=%0d exp=3", count_o); end
        apply(1'b1, 16'hDEAD, 16'h0DEA, 1'b0, 1'b1);
        checks++; if (v_o !== 1'b0 || count_o !== 3'd0) begin errors++; $display("FAIL flush_state got=%b/%0d exp=0/0", v_o, count_o); end
        apply(1'b1, 16'hBEEF, 16'h0300, 1'b1, 1'b0);
        checks++; if (v_o !== 1'b1 || inst_o !== 16'hBEEF || origaddr_o !== 16'h0300) begin errors++; $display("FAIL flush_head got=%b/%h/%h exp=1/beef/0300", v_o, inst_o, origaddr_o); end
        checks++; if (count_o !== 3'd1) begin errors++; $display("FAIL flush_count got=%0d exp=1", count_o); end
        apply(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        checks++; if (!popped || got_pop !== exp_pop) begin errors++; $display("FAIL flush_pop got=%h exp=%h", got_pop, exp_pop); end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 4; i++) apply(1'b1, 16'hB000 + 16'(i), 16'h0600 + 16'(i), 1'b1, 1'b0);
        apply(1'b1, 16'h9999, 16'h0999, 1'b1, 1'b0);
        checks++; if (ovf_o !== movf || ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", ovf_o); end
        checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL ovf_count got=%0d exp=4", count_o); end
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            checks++; if (!popped || got_pop !== exp_pop) begin errors++; $display("FAIL ovf_drain[%0d] got=%h exp=%h", i, got_pop, exp_pop); end
        end
        checks++; if (v_o !== 1'b0 || ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b/%b exp=0/1", v_o, ovf_o); end
        do_reset(1);
        for (int i = 0; i < 4; i++) apply(1'b1, 16'hE000 + 16'(i), 16'h0700 + 16'(i), 1'b1, 1'b0);
        apply(1'b1, 16'h9999, 16'h0999, 1'b0, 1'b0);
        checks++; if (!popped || got_pop !== exp_pop) begin errors++; $display("FAIL full_pop got=%h exp=%h", got_pop, exp_pop); end
        checks++; if (ovf_o !== 1'b0 || count_o !== 3'd4) begin errors++; $display("FAIL full_push got=%b/%0d exp=0/4", ovf_o, count_o); end
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            checks++; if (!popped || got_pop !== exp_pop) begin errors++; $display("FAIL full_drain[%0d] got=%h exp=%h", i, got_pop, exp_pop); end
        end
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL full_empty got=%0d exp=0", count_o); end
    endtask

    task automatic test_midreset;
        apply(1'b1, 16'h2222, 16'h0802, 1'b1, 1'b0);
        apply(1'b1, 16'h3333, 16'h0803, 1'b1, 1'b0);
        checks++; if (count_o !== 3'd2) begin errors++; $display("FAIL midrst_pre got=%0d exp=2", count_o); end
        do_reset(1);
        checks++; if (v_o !== 1'b0 || count_o !== 3'd0) begin errors++; $display("FAIL midrst_state got=%b/%0d exp=0/0", v_o, count_o); end
        apply(1'b1, 16'h5555, 16'h0500, 1'b1, 1'b0);
        checks++; if (v_o !== 1'b1 || inst_o !== 16'h5555 || origaddr_o !== 16'h0500) begin errors++; $display("FAIL midrst_head got=%b/%h/%h exp=1/5555/0500", v_o, inst_o, origaddr_o); end
        apply(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        checks++; if (!popped || got_pop !== exp_pop) begin errors++; $display("FAIL midrst_pop got=%h exp=%h", got_pop, exp_pop); end
    endtask

    // Scenario sequence.
    initial begin
        rst = 1'b0; v_i = 1'b0; inst_i = '0; origaddr_i = '0; flush_i = 1'b0; stall_i = 1'b0;
        mcount = 0; movf = 1'b0;
        popped = 1'b0; got_v = 1'b0; got_pop = '0; exp_pop = '0;
        @(negedge clk);
        test_reset();
        test_fill_drain();
        test_stream();
        test_flush();
        test_overflow();
        test_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
